// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding and sizing helpers
// for the bit-serial adder.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int MAX_WIDTH = 32;

    // Bit counter never collapses to zero width, even for WIDTH=1.
    function automatic int cnt_bits(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fulladd.sv
// fulladd: single-bit full-adder cell, the only arithmetic
// element of the serial datapath.
module fulladd (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: LSB-first bit-serial adder sequencer with
// valid/ready on both sides. SERIAL_ADD_SUB_EN adds a 'sub' input.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] b_ld;
    logic             c_ld;
    logic             fa_s;
    logic             fa_c;

    // Subtraction is a + ~b + 1, so cout=1 means no borrow.
`ifdef SERIAL_ADD_SUB_EN
    assign b_ld = sub ? ~b : b;
    assign c_ld = sub | cin;
`else
    assign b_ld = b;
    assign c_ld = cin;
`endif

    fulladd u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b_ld;
                    carry_d  = c_ld;
                    cnt_d    = '0;
                    sum_sh_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                sum_sh_d = (sum_sh_q >> 1) | (fa_s ? MSB : '0);
                carry_d  = fa_c;
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // Result registers latch on the final bit so they hold after handshake.
                if (cnt_q == LAST) begin
                    sum_d   = sum_sh_d;
                    cout_d  = fa_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed plus randomized checks of the
// bit-serial adder against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    logic         w1_in_valid = 1'b0;
    logic         w1_out_ready = 1'b0;
    logic         w1_a = 1'b0;
    logic         w1_b = 1'b0;
    logic         w1_cin = 1'b0;
    logic         w1_in_ready;
    logic         w1_out_valid;
    logic         w1_sum;
    logic         w1_cout;
    logic         w1_busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    serial_add_ctrl #(.WIDTH(1)) u_w1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (w1_in_valid),
        .in_ready  (w1_in_ready),
        .a         (w1_a),
        .b         (w1_b),
        .cin       (w1_cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (1'b0),
`endif
        .out_valid (w1_out_valid),
        .out_ready (w1_out_ready),
        .sum       (w1_sum),
        .cout      (w1_cout),
        .busy      (w1_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {cout,sum}: a+b+cin for add; a - b + 2^W for subtract.
    function automatic logic [W:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic ci, input logic s);
        longint r;
        if (s) r = longint'(x) + (longint'(1) << W) - longint'(y);
        else   r = longint'(x) + longint'(y) + longint'(ci);
        return r[W:0];
    endfunction

    task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic s);
        a = x;
        b = y;
        cin = ci;
        sub = s;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("accept busy", busy, 1'b1);
        check("accept in_ready", in_ready, 1'b0);
    endtask

    task automatic wait_done(input string tag, input logic [W:0] exp);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, " latency"}, 64'(n), 64'(W));
        check({tag, " sum"}, sum, exp[W-1:0]);
        check({tag, " cout"}, cout, exp[W]);
    endtask

    task automatic hold(input int k, input logic [W:0] exp);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold out_valid", out_valid, 1'b1);
            check("hold sum", sum, exp[W-1:0]);
            check("hold cout", cout, exp[W]);
            check("hold in_ready", in_ready, 1'b0);
        end
    endtask

    task automatic handshake(input logic [W:0] exp);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("hs out_valid", out_valid, 1'b0);
        check("hs in_ready", in_ready, 1'b1);
        check("hs busy", busy, 1'b0);
        check("hs sum held", sum, exp[W-1:0]);
        check("hs cout held", cout, exp[W]);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic ci,
                          input logic s, input int stall);
        logic [W:0] e;
        e = model(x, y, ci, s);
        accept(x, y, ci, s);
        wait_done(tag, e);
        hold(stall, e);
        handshake(e);
    endtask

    initial begin
        logic [W:0] e1;
        logic [W:0] e2;
        int seen;
        int n;

        repeat (2) @(negedge clk);
        check("rst in_ready", in_ready, 1'b1);
        check("rst out_valid", out_valid, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst sum", sum, '0);
        check("rst cout", cout, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        run_op("basic", 8'h5A, 8'h3C, 1'b0, 1'b0, 0);
        check("basic const", {cout, sum}, 9'h096);
        run_op("carry1", 8'hFF, 8'h01, 1'b0, 1'b0, 0);
        check("carry1 const", {cout, sum}, 9'h100);
        run_op("carry2", 8'hFF, 8'hFF, 1'b1, 1'b0, 0);
        check("carry2 const", {cout, sum}, 9'h1FF);

        e1 = model(8'hC3, 8'h7E, 1'b1, 1'b0);
        e2 = model(8'h21, 8'h42, 1'b0, 1'b0);
        accept(8'hC3, 8'h7E, 1'b1, 1'b0);
        wait_done("bp first", e1);
        a = 8'h21;
        b = 8'h42;
        cin = 1'b0;
        in_valid = 1'b1;
        hold(5, e1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp idle out_valid", out_valid, 1'b0);
        check("bp idle in_ready", in_ready, 1'b1);
        accept(8'h21, 8'h42, 1'b0, 1'b0);
        wait_done("bp second", e2);
        handshake(e2);

        accept(8'h11, 8'h22, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        check("mid rst busy", busy, 1'b0);
        check("mid rst in_ready", in_ready, 1'b1);
        check("mid rst out_valid", out_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        check("mid rst no result", 64'(seen), 64'(0));
        run_op("after rst", 8'h01, 8'h02, 1'b0, 1'b0, 0);
        check("after rst const", {cout, sum}, 9'h003);

`ifdef SERIAL_ADD_SUB_EN
        run_op("sub1", 8'h10, 8'h01, 1'b1, 1'b1, 0);
        check("sub1 const", {cout, sum}, 9'h10F);
        run_op("sub2", 8'h00, 8'h01, 1'b0, 1'b1, 0);
        check("sub2 const", {cout, sum}, 9'h0FF);
`endif

        for (int i = 0; i < 24; i++) begin
            logic s_r;
`ifdef SERIAL_ADD_SUB_EN
            s_r = 1'($urandom_range(0, 1));
`else
            s_r = 1'b0;
`endif
            run_op("rand", W'($urandom), W'($urandom),
                   1'($urandom_range(0, 1)), s_r,
                   int'($urandom_range(0, 3)));
        end

        w1_a = 1'b1;
        w1_b = 1'b1;
        w1_cin = 1'b1;
        w1_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        w1_in_valid = 1'b0;
        n = 0;
        while (w1_out_valid !== 1'b1 && n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("w1 latency", 64'(n), 64'(1));
        check("w1 sum", w1_sum, 1'b1);
        check("w1 cout", w1_cout, 1'b1);
        check("w1 busy", w1_busy, 1'b1);
        w1_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        w1_out_ready = 1'b0;
        check("w1 hs out_valid", w1_out_valid, 1'b0);
        check("w1 hs in_ready", w1_in_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
